// File: rtl/jtframe_rom_2slots.sv
// Two ROM clients share one SDRAM read port through one-word (32-bit) caches and round-robin refills.
// Define JTFRAME_ROM_TIMEOUT_EN to drop a read whose data has not arrived 255 cycles after the ack.
module jtframe_rom_2slots #(
  parameter int          SLOT0_AW     = 17,
  parameter int          SLOT0_DW     = 8,
  parameter logic [21:0] SLOT0_OFFSET = 22'h0,
  parameter int          SLOT1_AW     = 15,
  parameter int          SLOT1_DW     = 16,
  parameter logic [21:0] SLOT1_OFFSET = 22'h10_0000
) (
  input  logic                clk_rom,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic                slot0_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  output logic [SLOT0_DW-1:0] slot0_dout,
  output logic                slot0_ok,
  input  logic                slot1_cs,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  output logic [SLOT1_DW-1:0] slot1_dout,
  output logic                slot1_ok,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic [21:0]         sdram_addr,
  input  logic [31:0]         data_read,
  input  logic                data_rdy
);

  localparam int TW0 = (SLOT0_DW == 8) ? SLOT0_AW - 2 : SLOT0_AW - 1;
  localparam int TW1 = (SLOT1_DW == 8) ? SLOT1_AW - 2 : SLOT1_AW - 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;
  state_t state_reg, state_next;

  logic [TW0-1:0] cur_tag0, tag0_reg, req_tag0_reg;
  logic [TW1-1:0] cur_tag1, tag1_reg, req_tag1_reg;
  logic [31:0]    cache0_reg, cache1_reg;
  logic           valid0_reg, valid1_reg;
  logic           last_reg, sel_reg;
  logic [21:0]    base0, base1;
  logic           hit0, hit1, miss0, miss1;
  logic           pick, issue, fill, timeout;

  assign cur_tag0 = slot0_addr[SLOT0_AW-1 -: TW0];
  assign cur_tag1 = slot1_addr[SLOT1_AW-1 -: TW1];

  // The cache line is always an even 16-bit word pair; the sum wraps at 22 bits.
  assign base0 = SLOT0_OFFSET + 22'({cur_tag0, 1'b0});
  assign base1 = SLOT1_OFFSET + 22'({cur_tag1, 1'b0});

  assign hit0  = valid0_reg && (tag0_reg == cur_tag0);
  assign hit1  = valid1_reg && (tag1_reg == cur_tag1);
  assign miss0 = slot0_cs && !hit0 && !downloading;
  assign miss1 = slot1_cs && !hit1 && !downloading;

  assign slot0_ok = slot0_cs && hit0 && !downloading;
  assign slot1_ok = slot1_cs && hit1 && !downloading;

  generate
    if (SLOT0_DW == 8) begin : g_slot0_byte
      assign slot0_dout = cache0_reg[{slot0_addr[1:0], 3'b000} +: 8];
    end else begin : g_slot0_half
      assign slot0_dout = cache0_reg[{slot0_addr[0], 4'b0000} +: 16];
    end
    if (SLOT1_DW == 8) begin : g_slot1_byte
      assign slot1_dout = cache1_reg[{slot1_addr[1:0], 3'b000} +: 8];
    end else begin : g_slot1_half
      assign slot1_dout = cache1_reg[{slot1_addr[0], 4'b0000} +: 16];
    end
  endgenerate

`ifdef JTFRAME_ROM_TIMEOUT_EN
  logic [7:0] wait_cnt_reg;

  // Held at zero outside WAIT_RDY so every wait starts counting from 0.
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= 8'd0;
    end else if (state_reg != WAIT_RDY) begin
      wait_cnt_reg <= 8'd0;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + 8'd1;
    end
  end

  assign timeout = (state_reg == WAIT_RDY) && (wait_cnt_reg == 8'hff);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (downloading) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:     if (miss0 || miss1)      state_next = WAIT_ACK;
        WAIT_ACK: if (sdram_ack)           state_next = WAIT_RDY;
        WAIT_RDY: if (data_rdy || timeout) state_next = IDLE;
        default:                           state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    sdram_req = (state_reg == WAIT_ACK) && !downloading;
    issue     = (state_reg == IDLE) && (miss0 || miss1);
    fill      = (state_reg == WAIT_RDY) && data_rdy && !downloading;
    // On a conflict the slot that was not served last wins.
    pick      = (miss0 && miss1) ? !last_reg : miss1;
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      sdram_addr   <= 22'd0;
      sel_reg      <= 1'b0;
      last_reg     <= 1'b1;
      req_tag0_reg <= '0;
      req_tag1_reg <= '0;
      tag0_reg     <= '0;
      tag1_reg     <= '0;
      cache0_reg   <= 32'd0;
      cache1_reg   <= 32'd0;
      valid0_reg   <= 1'b0;
      valid1_reg   <= 1'b0;
    end else begin
      if (issue) begin
        sdram_addr   <= pick ? base1 : base0;
        sel_reg      <= pick;
        req_tag0_reg <= cur_tag0;
        req_tag1_reg <= cur_tag1;
      end
      if (downloading) begin
        valid0_reg <= 1'b0;
        valid1_reg <= 1'b0;
      end else if (fill) begin
        last_reg <= sel_reg;
        if (sel_reg) begin
          cache1_reg <= data_read;
          tag1_reg   <= req_tag1_reg;
          valid1_reg <= 1'b1;
        end else begin
          cache0_reg <= data_read;
          tag0_reg   <= req_tag0_reg;
          valid0_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtframe_rom_2slots.sv
// Directed and randomized checks of jtframe_rom_2slots acting as its SDRAM controller,
// with a cache/memory reference model for the random phase.
module tb_jtframe_rom_2slots;

  logic        clk_rom = 1'b0;
  logic        rst_n = 1'b1;
  logic        downloading = 1'b0;
  logic        slot0_cs = 1'b0;
  logic [16:0] slot0_addr = '0;
  logic [7:0]  slot0_dout;
  logic        slot0_ok;
  logic        slot1_cs = 1'b0;
  logic [14:0] slot1_addr = '0;
  logic [15:0] slot1_dout;
  logic        slot1_ok;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic [21:0] sdram_addr;
  logic [31:0] data_read = '0;
  logic        data_rdy = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_rom = ~clk_rom;

  jtframe_rom_2slots #(
    .SLOT0_AW(17), .SLOT0_DW(8),  .SLOT0_OFFSET(22'h0),
    .SLOT1_AW(15), .SLOT1_DW(16), .SLOT1_OFFSET(22'h10_0000)
  ) dut (
    .clk_rom(clk_rom), .rst_n(rst_n), .downloading(downloading),
    .slot0_cs(slot0_cs), .slot0_addr(slot0_addr), .slot0_dout(slot0_dout), .slot0_ok(slot0_ok),
    .slot1_cs(slot1_cs), .slot1_addr(slot1_addr), .slot1_dout(slot1_dout), .slot1_ok(slot1_ok),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
    .data_read(data_read), .data_rdy(data_rdy)
  );

  task automatic tick();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference memory: 16-bit words, a 32-bit read returns {word[a+1], word[a]}.
  function automatic logic [15:0] hw(input logic [21:0] x);
    logic [31:0] t;
    t = {10'd0, x} * 32'd40503;
    return t[15:0] ^ 16'h5a3c;
  endfunction

  function automatic logic [31:0] mem(input logic [21:0] w);
    return {hw(w + 22'd1), hw(w)};
  endfunction

  function automatic logic [21:0] word0(input logic [16:0] a);
    return 22'(a / 4) * 22'd2;
  endfunction

  function automatic logic [21:0] word1(input logic [14:0] a);
    return 22'h10_0000 + 22'(a / 2) * 22'd2;
  endfunction

  function automatic logic [7:0] exp_b0(input logic [21:0] w, input logic [16:0] a);
    logic [31:0] d;
    int k;
    d = mem(w);
    k = int'(a % 4);
    return d[8*k +: 8];
  endfunction

  function automatic logic [15:0] exp_h1(input logic [21:0] w, input logic [14:0] a);
    return hw(w + 22'(a % 2));
  endfunction

  // Answer one SDRAM request: ack after ack_dly cycles, data_rdy rdy_dly cycles after the ack.
  task automatic serve(input int ack_dly, input int rdy_dly, input logic [31:0] d, output logic [21:0] a);
    int n;
    n = 0;
    while (sdram_req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("serve_req_seen", sdram_req, 1);
    a = sdram_addr;
    repeat (ack_dly) begin
      tick();
      chk("serve_req_hold", sdram_req, 1);
      chk("serve_addr_hold", sdram_addr, a);
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("serve_req_drop", sdram_req, 0);
    repeat (rdy_dly) tick();
    data_read = d;
    data_rdy = 1'b1;
    tick();
    data_rdy = 1'b0;
    data_read = $urandom;
    $display("txn: addr=%06h data=%08h", a, d);
  endtask

  logic [21:0] got;
  logic        v0, v1, prev_m0, prev_m1, fill_p, e0, e1;
  logic [21:0] cw0, cw1, prev_a0, prev_a1, fw;
  int          ph, cnt, seen, n;

  initial begin
    // Reset behaviour, including the cycle after release.
    #1 rst_n = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_req", sdram_req, 0);
      chk("rst_ok0", slot0_ok, 0);
      chk("rst_ok1", slot1_ok, 0);
      chk("rst_dout0", slot0_dout, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("rel_req", sdram_req, 0);
    chk("rel_ok0", slot0_ok, 0);
    chk("rel_ok1", slot1_ok, 0);
    chk("rel_dout0", slot0_dout, 0);

    // Single slot 0 miss, fill, then a hit on another byte of the same word.
    slot0_cs = 1'b1;
    slot0_addr = 17'h5;
    #1;
    chk("miss_ok0", slot0_ok, 0);
    chk("miss_req_early", sdram_req, 0);
    tick();
    chk("miss_req", sdram_req, 1);
    chk("miss_addr", sdram_addr, 22'h2);
    serve(3, 2, 32'h4433_2211, got);
    chk("fill_ok0", slot0_ok, 1);
    chk("fill_dout0", slot0_dout, 8'h22);
    slot0_addr = 17'h7;
    #1;
    chk("hit_ok0", slot0_ok, 1);
    chk("hit_dout0", slot0_dout, 8'h44);
    repeat (5) begin
      tick();
      chk("hit_noreq", sdram_req, 0);
    end

    // Both slots miss straight out of reset: slot 0 first, slot 1 right after.
    rst_n = 1'b0;
    tick();
    slot0_addr = 17'h5;
    slot1_cs = 1'b1;
    slot1_addr = 15'h3;
    tick();
    chk("rr_rst_req", sdram_req, 0);
    rst_n = 1'b1;
    tick();
    chk("rr_first_req", sdram_req, 1);
    chk("rr_first_addr", sdram_addr, 22'h2);
    serve(0, 1, 32'h4433_2211, got);
    chk("rr_ok0", slot0_ok, 1);
    chk("rr_ok1_pending", slot1_ok, 0);
    tick();
    chk("rr_second_req", sdram_req, 1);
    chk("rr_second_addr", sdram_addr, 22'h10_0002);
    serve(1, 0, 32'hbeef_1234, got);
    chk("rr_ok1", slot1_ok, 1);
    chk("rr_dout1", slot1_dout, 16'hbeef);
    chk("rr_ok0_kept", slot0_ok, 1);

    // Address change while the request is in flight.
    rst_n = 1'b0;
    slot1_cs = 1'b0;
    slot0_addr = 17'h5;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mf_req", sdram_req, 1);
    chk("mf_addr", sdram_addr, 22'h2);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    slot0_addr = 17'h10;
    tick();
    data_read = 32'h4433_2211;
    data_rdy = 1'b1;
    tick();
    data_rdy = 1'b0;
    chk("mf_ok0_stale", slot0_ok, 0);
    chk("mf_dout0_cache", slot0_dout, 8'h11);
    tick();
    chk("mf_rereq", sdram_req, 1);
    chk("mf_rereq_addr", sdram_addr, 22'h8);
    serve(0, 0, 32'ha1b2_c3d4, got);
    chk("mf_ok0", slot0_ok, 1);
    chk("mf_dout0", slot0_dout, 8'hd4);

    // downloading while waiting for data: abort, invalidate, ignore data_rdy, reissue after.
    slot1_cs = 1'b1;
    slot1_addr = 15'h3;
    tick();
    chk("dl_s1_addr", sdram_addr, 22'h10_0002);
    serve(1, 1, 32'h5678_9abc, got);
    chk("dl_s1_ok", slot1_ok, 1);
    chk("dl_s1_dout", slot1_dout, 16'h5678);
    slot0_addr = 17'h20;
    #1;
    chk("dl_s0_miss", slot0_ok, 0);
    tick();
    chk("dl_s0_req", sdram_req, 1);
    chk("dl_s0_addr", sdram_addr, 22'h10);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    tick();
    chk("dl_ok1_before", slot1_ok, 1);
    downloading = 1'b1;
    #1;
    chk("dl_ok0", slot0_ok, 0);
    chk("dl_ok1", slot1_ok, 0);
    chk("dl_req", sdram_req, 0);
    tick();
    data_read = 32'hdead_beef;
    data_rdy = 1'b1;
    tick();
    data_rdy = 1'b0;
    repeat (3) begin
      tick();
      chk("dl_hold_req", sdram_req, 0);
      chk("dl_hold_ok1", slot1_ok, 0);
    end
    downloading = 1'b0;
    #1;
    chk("dl_inval0", slot0_ok, 0);
    chk("dl_inval1", slot1_ok, 0);
    chk("dl_rdy_ignored", slot0_dout, 8'hd4);
    tick();
    chk("dl_reissue_req", sdram_req, 1);
    chk("dl_reissue_addr", sdram_addr, 22'h10);
    serve(0, 0, 32'h0bad_f00d, got);
    chk("dl_re_ok0", slot0_ok, 1);
    chk("dl_re_dout0", slot0_dout, 8'h0d);
    tick();
    chk("dl_re_addr1", sdram_addr, 22'h10_0002);
    serve(0, 2, 32'h1357_2468, got);
    chk("dl_re_ok1", slot1_ok, 1);
    chk("dl_re_dout1", slot1_dout, 16'h1357);

    // Data never arrives after the ack.
    slot0_addr = 17'h40;
    tick();
    chk("to_first_addr", sdram_addr, 22'h20);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
`ifdef JTFRAME_ROM_TIMEOUT_EN
    n = 0;
    while (sdram_req !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("to_req", sdram_req, 1);
    chk("to_addr", sdram_addr, 22'h20);
    chk("to_delay", (n >= 250 && n <= 270), 1);
`else
    seen = 0;
    repeat (1000) begin
      tick();
      if (sdram_req !== 1'b0) seen = 1;
    end
    chk("noto_req_quiet", seen, 0);
`endif
    downloading = 1'b1;
    slot0_cs = 1'b0;
    slot1_cs = 1'b0;
    tick();
    downloading = 1'b0;

    // Random traffic against the cache/memory model.
    v0 = 1'b0; v1 = 1'b0; cw0 = '0; cw1 = '0;
    prev_m0 = 1'b0; prev_m1 = 1'b0; prev_a0 = '0; prev_a1 = '0;
    fill_p = 1'b0; fw = '0; ph = 0; cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      sdram_ack = 1'b0;
      data_rdy = 1'b0;
      if (fill_p) begin
        if (fw >= 22'h10_0000) begin
          v1 = 1'b1;
          cw1 = fw;
        end else begin
          v0 = 1'b1;
          cw0 = fw;
        end
        fill_p = 1'b0;
      end
      if (ph == 0 && sdram_req === 1'b1) begin
        chk("rnd_req_addr", (prev_m0 && sdram_addr == prev_a0) || (prev_m1 && sdram_addr == prev_a1), 1);
        fw = sdram_addr;
        ph = 1;
        cnt = $urandom_range(0, 3);
        $display("txn: rnd addr=%06h", fw);
      end
      if (ph == 1) begin
        chk("rnd_req_hold", sdram_req, 1);
        chk("rnd_addr_hold", sdram_addr, fw);
        if (cnt == 0) begin
          sdram_ack = 1'b1;
          ph = 2;
          cnt = $urandom_range(0, 4);
        end else begin
          cnt--;
        end
      end else if (ph == 2) begin
        chk("rnd_req_low", sdram_req, 0);
        if (cnt == 0) begin
          data_rdy = 1'b1;
          data_read = mem(fw);
          fill_p = 1'b1;
          ph = 0;
        end else begin
          cnt--;
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        slot0_cs = ($urandom_range(0, 3) != 0);
        slot0_addr = 17'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 7) == 0) begin
        slot1_cs = ($urandom_range(0, 3) != 0);
        slot1_addr = 15'($urandom_range(0, 15));
      end
      #1;
      e0 = slot0_cs && v0 && (word0(slot0_addr) == cw0);
      e1 = slot1_cs && v1 && (word1(slot1_addr) == cw1);
      chk("rnd_ok0", slot0_ok, e0);
      chk("rnd_ok1", slot1_ok, e1);
      if (v0) chk("rnd_dout0", slot0_dout, exp_b0(cw0, slot0_addr));
      if (v1) chk("rnd_dout1", slot1_dout, exp_h1(cw1, slot1_addr));
      prev_m0 = slot0_cs && !e0;
      prev_m1 = slot1_cs && !e1;
      prev_a0 = word0(slot0_addr);
      prev_a1 = word1(slot1_addr);
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
